// File: rtl/quant_drain_ctrl_pkg.sv
// Shared types and default sizing for the accumulator-tile drain controller.
package quant_pkg;

  localparam int unsigned ARRAY_DIM              = 8;
  localparam int unsigned ACCUMULATOR_DATA_WIDTH = 16;
  localparam int unsigned COMPUTE_DATA_WIDTH     = 4;
  localparam int unsigned ADDR_WIDTH             = 8;
  localparam int unsigned QUANTIZER_SIZE         = ARRAY_DIM * ARRAY_DIM;
  localparam int unsigned ROW_W                  = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam int unsigned IDX_W                  = (QUANTIZER_SIZE > 1) ? $clog2(QUANTIZER_SIZE) : 1;
  localparam int unsigned ROW_DATA_W             = ARRAY_DIM * COMPUTE_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } qdrain_state_t;

  // Gather one row of quantizer results into a buffer word; column c lands at bits [c*W +: W].
  function automatic logic [ROW_DATA_W-1:0] pack_row(
    input logic [COMPUTE_DATA_WIDTH-1:0] results [QUANTIZER_SIZE],
    input logic [ROW_W-1:0]              row
  );
    logic [ROW_DATA_W-1:0] w_row;
    w_row = '0;
    for (int unsigned c = 0; c < ARRAY_DIM; c++) begin
      w_row[c*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH] =
        results[IDX_W'(32'(row) * ARRAY_DIM + c)];
    end
    return w_row;
  endfunction

endpackage

// File: rtl/quant_drain_ctrl_if.sv
// Unified-buffer row write port (valid/ready).
interface quant_drain_ctrl_if #(
  parameter int unsigned ADDR_W = quant_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_W = quant_pkg::ROW_DATA_W
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/quant_drain_ctrl.sv
// Captures one accumulator tile, holds it on the quantizer inputs and streams
// the quantized rows into the unified buffer one row per accepted write.
module quant_drain_ctrl #(
  parameter int unsigned ARRAY_DIM              = quant_pkg::ARRAY_DIM,
  parameter int unsigned ACCUMULATOR_DATA_WIDTH = quant_pkg::ACCUMULATOR_DATA_WIDTH,
  parameter int unsigned COMPUTE_DATA_WIDTH     = quant_pkg::COMPUTE_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH             = quant_pkg::ADDR_WIDTH,
  localparam int unsigned QUANTIZER_SIZE        = ARRAY_DIM * ARRAY_DIM
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              acc_valid,
  output logic                              acc_ready,
  input  logic [ACCUMULATOR_DATA_WIDTH-1:0] acc_tile  [QUANTIZER_SIZE],
  input  logic [ADDR_WIDTH-1:0]             dst_base,
  output logic [ACCUMULATOR_DATA_WIDTH-1:0] q_ins     [QUANTIZER_SIZE],
  input  logic [COMPUTE_DATA_WIDTH-1:0]     q_results [QUANTIZER_SIZE],
  quant_drain_ctrl_if.master                wr,
  output logic                              busy,
  output logic                              done
);

  import quant_pkg::*;

  localparam int unsigned RW   = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam int unsigned IW   = (QUANTIZER_SIZE > 1) ? $clog2(QUANTIZER_SIZE) : 1;
  localparam int unsigned DW   = ARRAY_DIM * COMPUTE_DATA_WIDTH;
  localparam logic [RW-1:0] LAST_ROW = RW'(ARRAY_DIM - 1);

  qdrain_state_t                     r_state;
  logic [RW-1:0]                     r_row;
  logic [ADDR_WIDTH-1:0]             r_addr;
  logic [ACCUMULATOR_DATA_WIDTH-1:0] r_tile [QUANTIZER_SIZE];
  logic                              r_wr_valid;
  logic                              r_acc_ready;
  logic                              r_busy;
  logic                              r_done;
  logic [DW-1:0]                     w_wr_data;
  logic                              w_xfer;

  assign w_xfer = r_wr_valid && wr.wr_ready;

  // Drain sequencer: capture in IDLE, one row per accepted write in DRAIN, one-cycle DONE pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_addr      <= '0;
      r_tile      <= '{default: '0};
      r_wr_valid  <= 1'b0;
      r_acc_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (acc_valid) begin
            r_tile      <= acc_tile;
            r_addr      <= dst_base;
            r_row       <= '0;
            r_wr_valid  <= 1'b1;
            r_acc_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_xfer) begin
            if (r_row == LAST_ROW) begin
              r_wr_valid <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_row  <= r_row + RW'(1);
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end
          end
        end
        DONE: begin
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_acc_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_wr_valid  <= 1'b0;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_acc_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // Row mux over the combinational quantizer results; stable while r_row is held.
  always_comb begin
    w_wr_data = '0;
    for (int unsigned c = 0; c < ARRAY_DIM; c++) begin
      w_wr_data[c*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH] =
        q_results[IW'(32'(r_row) * ARRAY_DIM + c)];
    end
  end

  assign q_ins       = r_tile;
  assign acc_ready   = r_acc_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign wr.wr_valid = r_wr_valid;
  assign wr.wr_addr  = r_addr;
  assign wr.wr_data  = w_wr_data;

endmodule

// File: tb/tb_quant_drain_ctrl.sv
// Bench for quant_drain_ctrl with a behavioural stand-in for quantizer_array.
module tb_quant_drain_ctrl;

  localparam int unsigned DIM = 8;
  localparam int unsigned QS  = DIM * DIM;
  localparam int unsigned AW  = 16;
  localparam int unsigned CW  = 4;
  localparam int unsigned ADW = 8;
  localparam int unsigned RDW = DIM * CW;

  typedef struct {
    int              cyc;
    logic [ADW-1:0]  addr;
    logic [RDW-1:0]  data;
  } rec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           acc_valid;
  logic           acc_ready;
  logic [AW-1:0]  acc_tile  [QS];
  logic [ADW-1:0] dst_base;
  logic [AW-1:0]  q_ins     [QS];
  logic [CW-1:0]  q_results [QS];
  logic           busy;
  logic           done;

  quant_drain_ctrl_if #(.ADDR_W(ADW), .DATA_W(RDW)) wr_if ();

  quant_drain_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_tile  (acc_tile),
    .dst_base  (dst_base),
    .q_ins     (q_ins),
    .q_results (q_results),
    .wr        (wr_if),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rec_t wr_log[$];
  int   acc_log[$];
  int   done_log[$];

  logic [AW-1:0] tile_a [QS];
  logic [AW-1:0] tile_b [QS];

  // Quantizer stand-in: arithmetic shift by 6 with signed 4-bit saturation.
  function automatic logic [CW-1:0] qfun(input logic [AW-1:0] a);
    int v;
    v = int'($signed(a)) >>> 6;
    if (v > 7) v = 7;
    if (v < -8) v = -8;
    return CW'(v);
  endfunction

  // Reference: expected buffer word for row r of a captured tile.
  function automatic logic [RDW-1:0] exp_row(input logic [AW-1:0] t [QS], input int r);
    logic [RDW-1:0] d;
    d = '0;
    for (int c = 0; c < int'(DIM); c++) d[c*CW +: CW] = qfun(t[r*int'(DIM) + c]);
    return d;
  endfunction

  always_comb begin
    for (int i = 0; i < int'(QS); i++) q_results[i] = qfun(q_ins[i]);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Observe tile acceptances, write transfers and done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (acc_valid && acc_ready) acc_log.push_back(cyc);
      if (wr_if.wr_valid && wr_if.wr_ready)
        wr_log.push_back('{cyc: cyc, addr: wr_if.wr_addr, data: wr_if.wr_data});
      if (done) done_log.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    acc_log.delete();
    done_log.delete();
  endtask

  task automatic rand_fill(output logic [AW-1:0] t [QS]);
    for (int i = 0; i < int'(QS); i++) t[i] = AW'($urandom);
  endtask

  // Offer a tile and return in the first drain cycle (row 0 presented).
  task automatic offer(input logic [AW-1:0] t [QS], input logic [ADW-1:0] b, input bit keep);
    int n0;
    bit ok;
    n0 = acc_log.size();
    ok = 1'b0;
    acc_tile  = t;
    dst_base  = b;
    acc_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (acc_log.size() > n0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!keep) acc_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL offer_timeout: tile not accepted within 40 cycles");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!busy && acc_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: controller still busy after 40 cycles");
    end
  endtask

  task automatic test_reset();
    bit qz;
    rst_n = 1'b0;
    acc_valid = 1'b0;
    dst_base = '0;
    for (int i = 0; i < int'(QS); i++) acc_tile[i] = '0;
    wr_if.wr_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL reset_acc_ready got %b want 1", acc_ready); end
    checks++; if (wr_if.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b want 0", wr_if.wr_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (wr_if.wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr got %h want 00", wr_if.wr_addr); end
    qz = 1'b1;
    for (int i = 0; i < int'(QS); i++) if (q_ins[i] !== '0) qz = 1'b0;
    checks++; if (qz !== 1'b1) begin errors++; $display("FAIL reset_q_ins got nonzero element want all 0"); end
  endtask

  task automatic test_basic();
    int n;
    clear_logs();
    wr_if.wr_ready = 1'b1;
    for (int i = 0; i < int'(QS); i++) tile_a[i] = AW'(i << 4);
    offer(tile_a, 8'h10, 1'b0);
    wait_idle();
    n = (acc_log.size() > 0) ? acc_log[0] : 0;
    checks++; if (cyc !== n + 10) begin errors++; $display("FAIL basic_ready_again cycle got %0d want %0d", cyc - n, 10); end
    checks++; if (wr_log.size() !== 8) begin errors++; $display("FAIL basic_write_count got %0d want 8", wr_log.size()); end
    for (int r = 0; r < 8 && r < wr_log.size(); r++) begin
      checks++;
      if (wr_log[r].addr !== ADW'(8'h10 + r) || wr_log[r].data !== exp_row(tile_a, r) || wr_log[r].cyc !== n + 1 + r) begin
        errors++;
        $display("FAIL basic_row%0d got addr=%h data=%h cyc=+%0d want addr=%h data=%h cyc=+%0d",
                 r, wr_log[r].addr, wr_log[r].data, wr_log[r].cyc - n, ADW'(8'h10 + r), exp_row(tile_a, r), 1 + r);
      end
    end
    checks++; if (done_log.size() !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_log.size()); end
    if (done_log.size() > 0) begin
      checks++; if (done_log[0] !== n + 9) begin errors++; $display("FAIL basic_done_cycle got +%0d want +9", done_log[0] - n); end
    end
  endtask

  task automatic test_stall();
    logic [ADW-1:0] b;
    int n;
    clear_logs();
    rand_fill(tile_a);
    b = ADW'($urandom_range(0, 200));
    wr_if.wr_ready = 1'b1;
    offer(tile_a, b, 1'b0);
    n = (acc_log.size() > 0) ? acc_log[0] : 0;
    step();
    step();
    wr_if.wr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (wr_if.wr_valid !== 1'b1 || wr_if.wr_addr !== ADW'(b + 2) || wr_if.wr_data !== exp_row(tile_a, 2)) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%b addr=%h data=%h want v=1 addr=%h data=%h",
                 k, wr_if.wr_valid, wr_if.wr_addr, wr_if.wr_data, ADW'(b + 2), exp_row(tile_a, 2));
      end
      step();
    end
    wr_if.wr_ready = 1'b1;
    wait_idle();
    checks++; if (wr_log.size() !== 8) begin errors++; $display("FAIL stall_write_count got %0d want 8", wr_log.size()); end
    for (int r = 0; r < 8 && r < wr_log.size(); r++) begin
      checks++;
      if (wr_log[r].addr !== ADW'(b + r) || wr_log[r].data !== exp_row(tile_a, r)) begin
        errors++;
        $display("FAIL stall_row%0d got addr=%h data=%h want addr=%h data=%h",
                 r, wr_log[r].addr, wr_log[r].data, ADW'(b + r), exp_row(tile_a, r));
      end
    end
    if (wr_log.size() >= 4) begin
      checks++;
      if (wr_log[2].cyc !== n + 6 || wr_log[3].cyc !== n + 7) begin
        errors++;
        $display("FAIL stall_timing got row2=+%0d row3=+%0d want +6 +7", wr_log[2].cyc - n, wr_log[3].cyc - n);
      end
    end
  endtask

  task automatic test_wrap();
    logic [ADW-1:0] wrap_addr [8];
    wrap_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    clear_logs();
    rand_fill(tile_a);
    rand_fill(tile_b);
    wr_if.wr_ready = 1'b1;
    offer(tile_a, 8'hFE, 1'b0);
    acc_tile  = tile_b;
    dst_base  = 8'h33;
    acc_valid = 1'b1;
    step();
    step();
    acc_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wrap_busy got %b want 1", busy); end
    wait_idle();
    checks++; if (acc_log.size() !== 1) begin errors++; $display("FAIL wrap_accepts got %0d want 1", acc_log.size()); end
    checks++; if (wr_log.size() !== 8) begin errors++; $display("FAIL wrap_write_count got %0d want 8", wr_log.size()); end
    for (int r = 0; r < 8 && r < wr_log.size(); r++) begin
      checks++;
      if (wr_log[r].addr !== wrap_addr[r] || wr_log[r].data !== exp_row(tile_a, r)) begin
        errors++;
        $display("FAIL wrap_row%0d got addr=%h data=%h want addr=%h data=%h",
                 r, wr_log[r].addr, wr_log[r].data, wrap_addr[r], exp_row(tile_a, r));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [ADW-1:0] b;
    clear_logs();
    rand_fill(tile_a);
    wr_if.wr_ready = 1'b1;
    offer(tile_a, ADW'($urandom), 1'b0);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    checks++; if (wr_if.wr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_wr_valid got %b want 0", wr_if.wr_valid); end
    rst_n = 1'b1;
    repeat (12) step();
    checks++; if (wr_log.size() !== 4) begin errors++; $display("FAIL rstmid_write_count got %0d want 4", wr_log.size()); end
    checks++; if (done_log.size() !== 0) begin errors++; $display("FAIL rstmid_done_count got %0d want 0", done_log.size()); end
    clear_logs();
    rand_fill(tile_b);
    b = ADW'($urandom);
    offer(tile_b, b, 1'b0);
    wait_idle();
    checks++; if (wr_log.size() !== 8) begin errors++; $display("FAIL rstmid_new_count got %0d want 8", wr_log.size()); end
    for (int r = 0; r < 8 && r < wr_log.size(); r++) begin
      checks++;
      if (wr_log[r].addr !== ADW'(b + r) || wr_log[r].data !== exp_row(tile_b, r)) begin
        errors++;
        $display("FAIL rstmid_new_row%0d got addr=%h data=%h want addr=%h data=%h",
                 r, wr_log[r].addr, wr_log[r].data, ADW'(b + r), exp_row(tile_b, r));
      end
    end
    checks++; if (done_log.size() !== 1) begin errors++; $display("FAIL rstmid_new_done got %0d want 1", done_log.size()); end
  endtask

  task automatic test_back_to_back();
    logic [ADW-1:0] ba, bb;
    bit ok;
    clear_logs();
    rand_fill(tile_a);
    rand_fill(tile_b);
    ba = ADW'($urandom);
    bb = ADW'($urandom);
    wr_if.wr_ready = 1'b1;
    offer(tile_a, ba, 1'b1);
    acc_tile = tile_b;
    dst_base = bb;
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (acc_log.size() >= 2) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    acc_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL b2b_second_accept not seen within 30 cycles");
    end
    wait_idle();
    if (acc_log.size() >= 2) begin
      checks++; if (acc_log[1] - acc_log[0] !== 10) begin errors++; $display("FAIL b2b_period got %0d want 10", acc_log[1] - acc_log[0]); end
    end
    checks++; if (wr_log.size() !== 16) begin errors++; $display("FAIL b2b_write_count got %0d want 16", wr_log.size()); end
    for (int w = 0; w < 16 && w < wr_log.size(); w++) begin
      logic [ADW-1:0] ea;
      logic [RDW-1:0] ed;
      ea = (w < 8) ? ADW'(ba + w) : ADW'(bb + (w - 8));
      ed = (w < 8) ? exp_row(tile_a, w) : exp_row(tile_b, w - 8);
      checks++;
      if (wr_log[w].addr !== ea || wr_log[w].data !== ed) begin
        errors++;
        $display("FAIL b2b_write%0d got addr=%h data=%h want addr=%h data=%h",
                 w, wr_log[w].addr, wr_log[w].data, ea, ed);
      end
    end
    checks++; if (done_log.size() !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_log.size()); end
  endtask

  initial begin
    acc_valid = 1'b0;
    wr_if.wr_ready = 1'b0;
    test_reset();
    test_basic();
    repeat (3) test_stall();
    test_wrap();
    test_reset_mid();
    repeat (2) test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
